// File: rtl/ssio_rx_delay_cal.sv
// RX input-delay calibration: sweeps all taps against a training pattern, then
// centres the delay in the longest contiguous passing window.
module ssio_rx_delay_cal #(
    parameter int WIDTH          = 1,
    parameter int TAP_W          = 5,
    parameter int NUM_TAPS       = 32,
    parameter int SETTLE_CYCLES  = 16,
    parameter int SAMPLE_BEATS   = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MIN_WINDOW     = 3,
    parameter int DEFAULT_TAP    = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [WIDTH-1:0] rx_q_i,
    input  logic             rx_valid_i,
    output logic [TAP_W-1:0] tap_value_o,
    output logic             tap_load_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [TAP_W-1:0] win_start_o,
    output logic [TAP_W:0]   win_len_o
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BEAT_W  = $clog2(SAMPLE_BEATS + 1);

    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_END    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [BEAT_W-1:0] BEAT_END   = BEAT_W'(SAMPLE_BEATS);
    localparam logic [TAP_W-1:0]  LAST_TAP   = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W-1:0]  DEF_TAP    = TAP_W'(DEFAULT_TAP);
    localparam logic [TAP_W:0]    MIN_LEN    = (TAP_W + 1)'(MIN_WINDOW);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_FINAL, S_FSETTLE, S_DONE, S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [TAP_W-1:0]    cur_tap_q, cur_tap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                mism_q, mism_d;
    logic [TAP_W-1:0]    run_start_q, run_start_d;
    logic [TAP_W:0]      run_len_q, run_len_d;
    logic [TAP_W-1:0]    best_start_q, best_start_d;
    logic [TAP_W:0]      best_len_q, best_len_d;
    logic [TAP_W-1:0]    tap_value_q, tap_value_d;
    logic                tap_load_q, tap_load_d;
    logic [TAP_W-1:0]    win_start_q, win_start_d;
    logic [TAP_W:0]      win_len_q, win_len_d;
    logic                tap_pass;
    logic [TAP_W-1:0]    seg_start;
    logic [TAP_W:0]      seg_len;

    assign cnt_inc  = cnt_q + 1'b1;
    assign tap_pass = (beat_q == BEAT_END) && !mism_q;

    always_comb begin
        state_d      = state_q;
        cur_tap_d    = cur_tap_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        mism_d       = mism_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        tap_value_d  = tap_value_q;
        tap_load_d   = 1'b0;
        win_start_d  = win_start_q;
        win_len_d    = win_len_q;
        seg_start    = run_start_q;
        seg_len      = run_len_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d      = S_LOAD;
                    cur_tap_d    = '0;
                    run_start_d  = '0;
                    run_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    tap_value_d  = '0;
                    tap_load_d   = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == SETTLE_END) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                    beat_d  = '0;
                    mism_d  = 1'b0;
                end
            end
            S_SAMPLE: begin
                cnt_d = cnt_inc;
                if (rx_valid_i) begin
                    beat_d = beat_q + 1'b1;
                    if (rx_q_i != pattern_i) mism_d = 1'b1;
                end
                if ((beat_d == BEAT_END) || (cnt_inc == TMO_END)) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (tap_pass) begin
                    if (run_len_q == '0) seg_start = cur_tap_q;
                    seg_len = run_len_q + 1'b1;
                end
                run_start_d = seg_start;
                run_len_d   = seg_len;
                // A window still open at the last tap is closed here too.
                if (!tap_pass || (cur_tap_q == LAST_TAP)) begin
                    if (seg_len > best_len_q) begin
                        best_start_d = seg_start;
                        best_len_d   = seg_len;
                    end
                    run_len_d = '0;
                end
                if (cur_tap_q == LAST_TAP) begin
                    state_d = S_FINAL;
                end else begin
                    state_d     = S_LOAD;
                    cur_tap_d   = cur_tap_q + 1'b1;
                    tap_value_d = cur_tap_q + 1'b1;
                    tap_load_d  = 1'b1;
                end
            end
            S_FINAL: begin
                if (best_len_q >= MIN_LEN) begin
                    tap_value_d = TAP_W'({1'b0, best_start_q} + ((best_len_q - 1'b1) >> 1));
                    win_start_d = best_start_q;
                end else begin
                    tap_value_d = DEF_TAP;
                    win_start_d = '0;
                end
                win_len_d  = best_len_q;
                tap_load_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_FSETTLE;
            end
            S_FSETTLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == SETTLE_END) begin
                    cnt_d   = '0;
                    state_d = (best_len_q >= MIN_LEN) ? S_DONE : S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cur_tap_q    <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            mism_q       <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            tap_value_q  <= '0;
            tap_load_q   <= 1'b0;
            win_start_q  <= '0;
            win_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_tap_q    <= cur_tap_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            mism_q       <= mism_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            tap_value_q  <= tap_value_d;
            tap_load_q   <= tap_load_d;
            win_start_q  <= win_start_d;
            win_len_q    <= win_len_d;
        end
    end

    assign tap_value_o = tap_value_q;
    assign tap_load_o  = tap_load_q;
    assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign done_o      = (state_q == S_DONE);
    assign fail_o      = (state_q == S_FAIL);
    assign win_start_o = win_start_q;
    assign win_len_o   = win_len_q;

endmodule
